load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the EX/MEM pipeline register and the byte-addressable data memory; drives that memory's address, write_data, mem_read and mem_write ports.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into memory accesses; the data memory always reads and writes 4 bytes (A..A+3).
- Presents a little-endian view to the core: the byte at address A is the least-significant byte of a word. Memory returns it in read_data[31:24].
- Sub-word stores use a read-modify-write sequence. Load results and errors go to writeback.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (fixed 32; other values unsupported)
MEM_SIZE, 8192, data memory size in bytes; used for range check

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (state IDLE)
req_op  in  2  01 load, 10 store, others illegal
req_funct3  in  3  RV32I funct3 width/sign code
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, core byte order
req_rd  in  5  destination register tag
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors
resp_rd  out  5  tag of the responding request
resp_err  out  1  misaligned, out-of-range or illegal op/funct3
mem_address  out  ADDR_WIDTH  to data memory address
mem_write_data  out  DATA_WIDTH  to data memory write_data
mem_read  out  1  to data memory mem_read
mem_write  out  1  to data memory mem_write
mem_read_data  in  DATA_WIDTH  from data memory read_data

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE. All registered outputs and the captured request are 0.
  - mem_write is gated combinationally with rst_n, so asserting reset during a write cycle suppresses that memory write.
- Accept: rising edge with req_valid && req_ready. The unit registers op, funct3, addr, wdata and rd. req_ready is 1 only in IDLE; there is no response backpressure.
- Checks are done at accept and give a single err flag:
  - illegal op, or funct3 not in {000,001,010,100,101} for loads / {000,001,010} for stores;
  - halfword with addr[0]=1; word with addr[1:0]≠0;
  - addr > MEM_SIZE-4, for all widths, because memory touches 4 bytes.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
  - IDLE→RESP on err (no memory access).
  - IDLE→LOAD for loads, IDLE→STORE for SW, IDLE→RMW_RD for SB/SH.
  - LOAD: mem_read=1, mem_address=addr. The formatted result is captured at the closing edge; →RESP.
  - STORE: mem_write=1, mem_write_data=byteswap(wdata). Memory commits at the closing edge; →RESP.
  - RMW_RD: mem_read=1. Capture the merged word; →RMW_WR.
  - RMW_WR: mem_write=1 with the merged word; →RESP.
  - RESP: resp_valid=1 for one cycle; →IDLE.
- Latency: resp_valid is high in cycle N after the accept edge, where N=1 for errors, 2 for loads and SW, 3 for SB/SH.
- Throughput: the next accept happens no earlier than the edge that ends RESP.
- Byte mapping, with r = mem_read_data:
  - LB: sext(r[31:24]); LBU: zext(r[31:24]).
  - LH: sext({r[23:16],r[31:24]}); LHU: zext of the same.
  - LW: {r[7:0],r[15:8],r[23:16],r[31:24]}.
  - SB merge: {wdata[7:0], r[23:0]}.
  - SH merge: {wdata[7:0], wdata[15:8], r[15:0]}.
  - SW: byteswap(wdata).
- mem_read and mem_write are never both high. Outside access states both are 0, and mem_address and mem_write_data are held at 0.
- The cycle period must exceed the memory access delay (5 ns default) so read data is stable before the capture edge.

Decomposition:
- Package lsu_pkg holds:
  - state enum;
  - op encodings (OP_LOAD=2'b01, OP_STORE=2'b10);
  - funct3 constants F3_B/H/W/BU/HU;
  - a byteswap32 function.
- One combinational sub-module, lsu_byte_lane, handles load extract/extend and store merge from (funct3, r, wdata).

Test Plan:
- Memory bytes at 0x100..0x103 = 0x11,0x22,0x33,0x84: LW 0x100 → resp_rdata 0x84332211, resp_valid in the 2nd cycle after accept.
- Same bytes: LB 0x103 → 0xFFFFFF84; LBU 0x103 → 0x00000084; LH 0x102 → 0xFFFF8433; LHU 0x102 → 0x00008433.
- SB 0x101 wdata 0xAB → bytes 0x11,0xAB,0x33,0x84 (0x100..0x103); mem_read high 1 cycle, then mem_write high 1 cycle; resp in the 3rd cycle; byte 0x104 unchanged.
- SW 0x200 wdata 0xDEADBEEF → bytes 0xEF,0xBE,0xAD,0xDE; a following LW 0x200 returns 0xDEADBEEF.
- Errors: LW 0x102, SH 0x101, and SB 0x1FFF (with MEM_SIZE=8192) → resp_err=1 in the 1st cycle, mem_read and mem_write never asserted, memory unchanged.
- Reset mid-operation: rst_n low at the edge entering RMW_WR → no memory write, state IDLE, resp_valid stays 0, req_ready=1 after reset releases.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory presents byte A in [31:24]; the core sees byte A in [7:0].
  function automatic logic [31:0] byteswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational load extract/extend and sub-word store merge between
// big-endian-lane memory data and the little-endian core view.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{rdata[31]}}, rdata[31:24]};
      F3_BU:   load_data = {24'h0, rdata[31:24]};
      F3_H:    load_data = {{16{rdata[23]}}, rdata[23:16], rdata[31:24]};
      F3_HU:   load_data = {16'h0, rdata[23:16], rdata[31:24]};
      F3_W:    load_data = byteswap32(rdata);
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    merge_data = byteswap32(wdata);
    case (funct3)
      F3_B:    merge_data = {wdata[7:0], rdata[23:0]};
      F3_H:    merge_data = {wdata[7:0], wdata[15:8], rdata[15:0]};
      default: merge_data = byteswap32(wdata);
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, sub-word stores done as
// read-modify-write against a 4-byte-wide data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 8192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(MEM_SIZE - 4);

  state_t          state;
  logic [2:0]      q_funct3;
  logic [31:0]     q_wdata;
  logic [4:0]      q_rd;
  logic            mem_write_q;
  logic            is_load;
  logic            is_store;
  logic            f3_ok;
  logic            align_ok;
  logic            err;
  logic [31:0]     load_data;
  logic [31:0]     merge_data;

  assign req_ready = (state == S_IDLE);
  // Reset asserted mid-write must stop the memory committing on that edge.
  assign mem_write = mem_write_q & rst_n;

  always_comb begin
    is_load  = (req_op == OP_LOAD);
    is_store = (req_op == OP_STORE);
    f3_ok    = 1'b0;
    if (is_load)
      f3_ok = (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else if (is_store)
      f3_ok = (req_funct3 inside {F3_B, F3_H, F3_W});
    case (req_funct3)
      F3_H, F3_HU: align_ok = ~req_addr[0];
      F3_W:        align_ok = (req_addr[1:0] == 2'b00);
      default:     align_ok = 1'b1;
    endcase
    err = ~f3_ok | ~align_ok | (req_addr > ADDR_MAX);
  end

  lsu_byte_lane u_byte_lane (
    .funct3     (q_funct3),
    .rdata      (mem_read_data),
    .wdata      (q_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      q_funct3       <= 3'h0;
      q_wdata        <= 32'h0;
      q_rd           <= 5'h0;
      mem_read       <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_rd        <= 5'h0;
      resp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            q_funct3 <= req_funct3;
            q_wdata  <= req_wdata;
            q_rd     <= req_rd;
            if (err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rd    <= req_rd;
              resp_rdata <= '0;
            end else if (is_load) begin
              state       <= S_LOAD;
              mem_read    <= 1'b1;
              mem_address <= req_addr;
            end else if (req_funct3 == F3_W) begin
              state          <= S_STORE;
              mem_write_q    <= 1'b1;
              mem_address    <= req_addr;
              mem_write_data <= byteswap32(req_wdata);
            end else begin
              state       <= S_RMW_RD;
              mem_read    <= 1'b1;
              mem_address <= req_addr;
            end
          end
        end
        S_LOAD: begin
          state       <= S_RESP;
          mem_read    <= 1'b0;
          mem_address <= '0;
          resp_valid  <= 1'b1;
          resp_rdata  <= load_data;
          resp_rd     <= q_rd;
        end
        S_RMW_RD: begin
          state          <= S_RMW_WR;
          mem_read       <= 1'b0;
          mem_write_q    <= 1'b1;
          mem_write_data <= merge_data;
        end
        S_STORE, S_RMW_WR: begin
          state          <= S_RESP;
          mem_write_q    <= 1'b0;
          mem_address    <= '0;
          mem_write_data <= '0;
          resp_valid     <= 1'b1;
          resp_rdata     <= '0;
          resp_rd        <= q_rd;
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_rd    <= 5'h0;
          resp_err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
